// File: rtl/wb_arbiter_if.sv
// Wishbone classic bus bundle shared by the upstream masters and the downstream port.
// The master modport drives the request side; the slave modport drives the response side.
interface wb_arbiter_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output addr, wdata, sel, we, stb, cyc, input rdata, ack, err);
  modport slave  (input addr, wdata, sel, we, stb, cyc, output rdata, ack, err);
endinterface

// File: rtl/wb_arbiter.sv
// M:1 round-robin Wishbone arbiter. The owner keeps the bus for its whole cyc, and a
// watchdog answers strobes that go unanswered for TIMEOUT cycles with err.
module wb_arbiter #(
  parameter int unsigned M       = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_arbiter_if.slave      bus_in [M-1:0],
  wb_arbiter_if.master     bus_out,
  output logic [M-1:0]     gnt_o
);

  localparam int unsigned    CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned    GW      = $clog2(M);
  localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};
  localparam logic [M-1:0]   ONE_M   = M'(1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last;
  logic [M-1:0]  r_gnt;
  logic [CW-1:0] r_cnt;

  logic [M-1:0]  w_cyc;
  logic [M-1:0]  w_stb;
  logic [M-1:0]  w_we;
  logic [31:0]   w_addr  [M];
  logic [31:0]   w_wdata [M];
  logic [3:0]    w_sel   [M];

  logic          w_o_cyc;
  logic          w_o_stb;
  logic          w_o_we;
  logic [31:0]   w_o_addr;
  logic [31:0]   w_o_wdata;
  logic [3:0]    w_o_sel;

  logic          w_resp;
  logic          w_wd_err;
  logic [CW-1:0] w_cnt_d;
  logic          w_any;
  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_idx;

  // r_gnt is nonzero only in BUSY, so it doubles as the response steering mask.
  for (genvar gi = 0; gi < M; gi++) begin : g_port
    assign w_cyc[gi]          = bus_in[gi].cyc;
    assign w_stb[gi]          = bus_in[gi].stb;
    assign w_we[gi]           = bus_in[gi].we;
    assign w_addr[gi]         = bus_in[gi].addr;
    assign w_wdata[gi]        = bus_in[gi].wdata;
    assign w_sel[gi]          = bus_in[gi].sel;
    assign bus_in[gi].rdata   = r_gnt[gi] ? bus_out.rdata : 32'h0;
    assign bus_in[gi].ack     = r_gnt[gi] & bus_out.ack;
    assign bus_in[gi].err     = r_gnt[gi] & (bus_out.err | w_wd_err);
  end

  always_comb begin
    w_o_cyc   = 1'b0;
    w_o_stb   = 1'b0;
    w_o_we    = 1'b0;
    w_o_addr  = 32'h0;
    w_o_wdata = 32'h0;
    w_o_sel   = 4'h0;
    if (r_state == StBusy) begin
      w_o_cyc   = w_cyc[r_grant];
      w_o_stb   = w_cyc[r_grant] & w_stb[r_grant];
      w_o_we    = w_we[r_grant];
      w_o_addr  = w_addr[r_grant];
      w_o_wdata = w_wdata[r_grant];
      w_o_sel   = w_sel[r_grant];
    end
  end

  assign bus_out.cyc   = w_o_cyc;
  assign bus_out.stb   = w_o_stb;
  assign bus_out.we    = w_o_we;
  assign bus_out.addr  = w_o_addr;
  assign bus_out.wdata = w_o_wdata;
  assign bus_out.sel   = w_o_sel;
  assign gnt_o         = r_gnt;

  // Walk from farthest to nearest so the requester closest after r_last wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    w_idx  = '0;
    for (int k = M; k >= 1; k--) begin
      w_idx = GW'((int'(r_last) + k) % M);
      if (w_cyc[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_resp   = bus_out.ack | bus_out.err;
  assign w_wd_err = (TIMEOUT != 0) && (r_state == StBusy) && w_o_stb && !w_resp &&
                    (r_cnt == TO_LAST);

  always_comb begin
    w_cnt_d = '0;
    if ((TIMEOUT != 0) && (r_state == StBusy) && w_o_stb && !w_resp && !w_wd_err) begin
      w_cnt_d = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_last  <= GW'(M - 1);
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= w_cnt_d;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_gnt   <= ONE_M << w_pick;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (!w_cyc[r_grant]) begin
            r_last  <= r_grant;
            r_gnt   <= '0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with fixed expectations, then random traffic
// compared each cycle against a cycle-level behavioural model of ownership and the watchdog.
module tb_wb_arbiter;
  localparam int unsigned M  = 2;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  gnt;

  logic [1:0]  d_cyc, d_stb, d_we;
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [3:0]  d_sel [2];
  logic        s_ack, s_err;
  logic [31:0] s_rdata;

  logic [1:0]  o_ack, o_err;
  logic [31:0] o_rd0, o_rd1;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model state: owner index (-1 when idle), last owner, unanswered strobe run.
  int m_owner, m_last, m_wait;
  logic [1:0]  e_gnt, e_ack, e_err;
  logic        e_cyc, e_stb, e_we, e_fire;
  logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
  logic [3:0]  e_sel;

  wb_arbiter_if u_in [1:0] ();
  wb_arbiter_if u_out ();

  wb_arbiter #(.M(M), .TIMEOUT(TO)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_in (u_in),
    .bus_out(u_out),
    .gnt_o  (gnt)
  );

  for (genvar g = 0; g < 2; g++) begin : g_drv
    assign u_in[g].cyc   = d_cyc[g];
    assign u_in[g].stb   = d_stb[g];
    assign u_in[g].we    = d_we[g];
    assign u_in[g].addr  = d_addr[g];
    assign u_in[g].wdata = d_wdata[g];
    assign u_in[g].sel   = d_sel[g];
  end

  assign u_out.ack   = s_ack;
  assign u_out.err   = s_err;
  assign u_out.rdata = s_rdata;
  assign o_ack = {u_in[1].ack, u_in[0].ack};
  assign o_err = {u_in[1].err, u_in[0].err};
  assign o_rd0 = u_in[0].rdata;
  assign o_rd1 = u_in[1].rdata;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    d_cyc = '0; d_stb = '0; d_we = '0;
    for (int i = 0; i < 2; i++) begin
      d_addr[i] = '0; d_wdata[i] = '0; d_sel[i] = '0;
    end
    s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    smp();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_out", {u_out.cyc, u_out.stb, u_out.we, u_out.sel, u_out.addr, u_out.wdata},
        '0);
    chk("rst_resp", {o_ack, o_err, o_rd0, o_rd1}, '0);

    // Single read
    step();
    d_cyc[0] = 1'b1; d_stb[0] = 1'b1; d_addr[0] = 32'h0000_1000; d_sel[0] = 4'hf;
    smp();
    chk("rd_t0_stb", u_out.stb, 1'b0);
    step();
    smp();
    chk("rd_t1_stb", u_out.stb, 1'b1);
    chk("rd_t1_addr", u_out.addr, 32'h0000_1000);
    chk("rd_t1_gnt", gnt, 2'b01);
    chk("rd_t1_ack", o_ack, 2'b00);
    step();
    s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    smp();
    chk("rd_t2_ack", o_ack, 2'b01);
    chk("rd_t2_rdata", o_rd0, 32'hDEAD_BEEF);
    chk("rd_t2_gnt", gnt, 2'b01);
    step();
    d_cyc = '0; d_stb = '0; s_ack = 1'b0;
    smp();
    chk("rd_t3_cyc", {u_out.cyc, u_out.stb}, 2'b00);
    step();
    smp();
    chk("rd_t4_gnt", gnt, 2'b00);

    // Simultaneous request
    do_reset();
    d_cyc = 2'b11; d_stb = 2'b11; d_we = 2'b11;
    d_addr[0] = 32'hA000_0000; d_addr[1] = 32'hB000_0000; s_ack = 1'b1;
    smp();
    chk("sim_t0", {gnt, o_ack}, 4'b0000);
    step();
    smp();
    chk("sim_t1_gnt", gnt, 2'b01);
    chk("sim_t1_addr", {u_out.we, u_out.addr}, {1'b1, 32'hA000_0000});
    chk("sim_t1_ack", o_ack, 2'b01);
    step();
    d_cyc[0] = 1'b0; d_stb[0] = 1'b0; s_ack = 1'b0;
    smp();
    chk("sim_t2", {gnt, u_out.cyc}, {2'b01, 1'b0});
    step();
    s_ack = 1'b1;
    smp();
    chk("sim_t3", {gnt, o_ack}, 4'b0000);
    step();
    smp();
    chk("sim_t4_gnt", gnt, 2'b10);
    chk("sim_t4_addr", u_out.addr, 32'hB000_0000);
    chk("sim_t4_ack", o_ack, 2'b10);
    step();
    d_cyc = '0; d_stb = '0; s_ack = 1'b0;
    step();
    d_cyc = 2'b11; d_stb = 2'b11;
    step();
    smp();
    chk("rr_second_contest", gnt, 2'b01);

    // Burst hold
    do_reset();
    d_cyc = 2'b10; d_stb = 2'b10; d_addr[1] = 32'h0000_2000;
    step();
    d_cyc = 2'b11; d_stb = 2'b11; s_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      smp();
      chk("burst_beat", {gnt, o_ack}, {2'b10, 2'b10});
    end
    step();
    d_cyc[1] = 1'b0; d_stb[1] = 1'b0; s_ack = 1'b0;
    smp();
    chk("burst_drop", {gnt, u_out.cyc}, {2'b10, 1'b0});
    step();
    s_ack = 1'b1;
    smp();
    chk("burst_idle", {gnt, o_ack}, 4'b0000);
    step();
    smp();
    chk("burst_handover", {gnt, o_ack}, {2'b01, 2'b01});

    // Timeout
    do_reset();
    d_cyc = 2'b01; d_stb = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      step();
      smp();
      chk("to_err", {o_err, o_ack}, {((k == 4) ? 2'b01 : 2'b00), 2'b00});
    end
    step();
    step();
    s_ack = 1'b1;
    smp();
    chk("to_ack_wins", {o_ack, o_err}, {2'b01, 2'b00});

    // Reset mid-transaction
    step();
    s_ack = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; d_cyc = 2'b11; d_stb = 2'b11; s_ack = 1'b1;
    smp();
    chk("rstmid_out", {gnt, u_out.cyc, u_out.stb}, 4'b0000);
    chk("rstmid_resp", {o_ack, o_err}, 4'b0000);
    step();
    smp();
    chk("rstmid_first", gnt, 2'b01);

    // Unmapped address: decode err passes through and clears the watchdog
    do_reset();
    d_cyc = 2'b01; d_stb = 2'b01; d_addr[0] = 32'hFFFF_0000;
    step();
    smp();
    chk("unm_t1_err", o_err, 2'b00);
    step();
    s_err = 1'b1;
    smp();
    chk("unm_t2_err", {o_err, o_ack}, {2'b01, 2'b00});
    for (int k = 1; k <= 4; k++) begin
      step();
      s_err = 1'b0;
      smp();
      chk("unm_wd_err", o_err, (k == 4) ? 2'b01 : 2'b00);
    end

    // Random traffic against the model
    do_reset();
    m_owner = -1; m_last = M - 1; m_wait = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 2; i++) begin
        if (d_cyc[i]) d_cyc[i] = ($urandom_range(0, 7) != 0);
        else d_cyc[i] = ($urandom_range(0, 2) == 0);
        d_stb[i] = ($urandom_range(0, 3) != 0);
        d_we[i] = 1'($urandom_range(0, 1));
        d_addr[i] = $urandom;
        d_wdata[i] = $urandom;
        d_sel[i] = 4'($urandom_range(0, 15));
      end
      s_ack = ($urandom_range(0, 3) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_rdata = $urandom;
      smp();

      e_gnt = '0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_addr = '0; e_wdata = '0; e_sel = '0;
      e_ack = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
      if (m_owner >= 0) begin
        e_gnt = 2'b01 << m_owner;
        e_cyc = d_cyc[m_owner];
        e_stb = d_cyc[m_owner] && d_stb[m_owner];
        e_we = d_we[m_owner];
        e_addr = d_addr[m_owner];
        e_wdata = d_wdata[m_owner];
        e_sel = d_sel[m_owner];
      end
      e_fire = e_stb && !s_ack && !s_err && (m_wait == TO - 1);
      if (m_owner >= 0) begin
        e_ack[m_owner] = s_ack;
        e_err[m_owner] = s_err || e_fire;
        if (m_owner == 0) e_rd0 = s_rdata;
        else e_rd1 = s_rdata;
      end

      chk("rnd_gnt", gnt, e_gnt);
      chk("rnd_out", {u_out.cyc, u_out.stb, u_out.we, u_out.sel, u_out.addr, u_out.wdata},
          {e_cyc, e_stb, e_we, e_sel, e_addr, e_wdata});
      chk("rnd_resp", {o_ack, o_err}, {e_ack, e_err});
      chk("rnd_rdata", {o_rd1, o_rd0}, {e_rd1, e_rd0});

      if (rst) begin
        m_owner = -1; m_last = M - 1; m_wait = 0;
      end else begin
        m_wait = (e_stb && !s_ack && !s_err && !e_fire) ? m_wait + 1 : 0;
        if (m_owner < 0) begin
          for (int k = 1; k <= M; k++) begin
            if (m_owner < 0 && d_cyc[(m_last + k) % M]) m_owner = (m_last + k) % M;
          end
        end else if (!d_cyc[m_owner]) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
